// File: rtl/lcd_text_streamer_if.sv
// Host/controller-facing signal bundle for lcd_text_streamer.
// The streamer connects through the slave modport; a host or bench drives the master side.
interface lcd_text_streamer_if #(
  parameter int AW = 5
) ();
  logic          iWrEn;
  logic [AW-1:0] iWrAddr;
  logic [7:0]    iWrData;
  logic          iStart;
  logic [AW:0]   iLength;
  logic          iLCD_Ready;
  logic          oWrite;
  logic [7:0]    oData;
  logic          oBusy;
  logic          oDone;
  logic          oError;
  logic [AW-1:0] oCharIndex;

  modport master (
    output iWrEn, iWrAddr, iWrData, iStart, iLength, iLCD_Ready,
    input  oWrite, oData, oBusy, oDone, oError, oCharIndex
  );

  modport slave (
    input  iWrEn, iWrAddr, iWrData, iStart, iLength, iLCD_Ready,
    output oWrite, oData, oBusy, oDone, oError, oCharIndex
  );
endinterface

// File: rtl/lcd_text_streamer.sv
// Streams a host-loaded character buffer to a character LCD controller,
// one write per controller-idle window, with a busy-acknowledge timeout.
module lcd_text_streamer #(
  parameter int DEPTH        = 32,
  parameter int AW           = 5,
  parameter bit TERM_NULL    = 1'b1,
  parameter int BUSY_TIMEOUT = 64
) (
  input logic                Clock,
  input logic                Reset,
  lcd_text_streamer_if.slave io_bus
);

  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_READY = 3'd1,
    S_ISSUE      = 3'd2,
    S_WAIT_BUSY  = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  state_t        r_state;
  logic [7:0]    r_buf [DEPTH];
  logic [AW:0]   r_len;
  logic [AW-1:0] r_index;
  logic [CW-1:0] r_tmo;
  logic          r_write;
  logic          r_busy;
  logic          r_done;
  logic          r_error;
  logic [7:0]    r_data;

  logic [AW:0]   w_len_eff;
  logic [7:0]    w_cur_char;
  logic          w_last;
  logic          w_null_stop;

  // Effective length clamp, current character and end-of-message decode.
  always_comb begin
    w_len_eff   = io_bus.iLength;
    w_cur_char  = r_buf[r_index];
    w_last      = ({1'b0, r_index} == (r_len - (AW + 1)'(1)));
    w_null_stop = 1'b0;
    if (io_bus.iLength > (AW + 1)'(DEPTH)) begin
      w_len_eff = (AW + 1)'(DEPTH);
    end else begin
      w_len_eff = io_bus.iLength;
    end
    if (TERM_NULL && (w_cur_char == 8'h00)) begin
      w_null_stop = 1'b1;
    end else begin
      w_null_stop = 1'b0;
    end
  end

  // Message buffer: host writes land in any state; reset fills with spaces.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= 8'h20;
      end
    end else if (io_bus.iWrEn) begin
      r_buf[io_bus.iWrAddr] <= io_bus.iWrData;
    end
  end

  // Streaming FSM; oDone is raised on the cycle after DONE so it trails oBusy.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_index <= '0;
      r_tmo   <= '0;
      r_write <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_data  <= 8'h00;
    end else begin
      r_write <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (io_bus.iStart) begin
            r_error <= 1'b0;
            r_busy  <= 1'b1;
            if (w_len_eff != (AW + 1)'(0)) begin
              r_len   <= w_len_eff;
              r_index <= '0;
              r_state <= S_WAIT_READY;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_WAIT_READY: begin
          if (w_null_stop) begin
            r_state <= S_DONE;
          end else if (io_bus.iLCD_Ready) begin
            r_data  <= w_cur_char;
            r_write <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_tmo   <= '0;
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          // Ready dropping is the controller's acknowledgement of the write.
          if (!io_bus.iLCD_Ready) begin
            if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_index <= r_index + AW'(1);
              r_state <= S_WAIT_READY;
            end
          end else if (r_tmo == CW'(BUSY_TIMEOUT - 1)) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + CW'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign io_bus.oWrite     = r_write;
  assign io_bus.oData      = r_data;
  assign io_bus.oBusy      = r_busy;
  assign io_bus.oDone      = r_done;
  assign io_bus.oError     = r_error;
  assign io_bus.oCharIndex = r_index;

endmodule

// File: tb/tb_lcd_text_streamer.sv
// Scoreboard bench: two streamers (TERM_NULL=1 and 0) share host stimulus,
// each paced by its own controller model; a monitor checks every write/done/error.
module tb_lcd_text_streamer;

  localparam int KW = 0;
  localparam int KD = 1;
  localparam int KE = 2;

  typedef struct {
    int kind;
    int data;
    int idx;
  } item_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = 5'd0;
  logic [7:0] wr_data = 8'd0;
  logic       i_start = 1'b0;
  logic [5:0] i_len = 6'd0;
  logic       stuck = 1'b0;
  int         busy_len = 100;

  int         tests = 0;
  int         fails = 0;
  int         model_buf [32];
  item_t      q0 [$];
  item_t      q1 [$];
  logic       prev_err [2];

  logic       o_write [2];
  logic       o_busy [2];
  logic       o_done [2];
  logic       o_err [2];
  logic [7:0] o_data [2];
  logic [4:0] o_idx [2];
  logic       rdy [2];

  always #5 clk = ~clk;

  lcd_text_streamer_if #(.AW(5)) bus0 ();
  lcd_text_streamer_if #(.AW(5)) bus1 ();

  lcd_text_streamer #(.DEPTH(32), .AW(5), .TERM_NULL(1'b1), .BUSY_TIMEOUT(64)) dut0 (
    .Clock(clk), .Reset(rst_n), .io_bus(bus0));
  lcd_text_streamer #(.DEPTH(32), .AW(5), .TERM_NULL(1'b0), .BUSY_TIMEOUT(64)) dut1 (
    .Clock(clk), .Reset(rst_n), .io_bus(bus1));

  // Character LCD controller model: ready drops the cycle after a write and stays low busy_len cycles.
  for (genvar g = 0; g < 2; g++) begin : g_lcd
    logic ready;
    int   cnt;
    always @(posedge clk) begin
      if (!rst_n) begin
        ready <= 1'b1;
        cnt   <= 0;
      end else if (stuck) begin
        ready <= 1'b1;
      end else if (o_write[g]) begin
        ready <= 1'b0;
        cnt   <= busy_len - 1;
      end else if (cnt > 0) begin
        cnt <= cnt - 1;
      end else begin
        ready <= 1'b1;
      end
    end
  end

  assign bus0.iWrEn = wr_en;     assign bus1.iWrEn = wr_en;
  assign bus0.iWrAddr = wr_addr; assign bus1.iWrAddr = wr_addr;
  assign bus0.iWrData = wr_data; assign bus1.iWrData = wr_data;
  assign bus0.iStart = i_start;  assign bus1.iStart = i_start;
  assign bus0.iLength = i_len;   assign bus1.iLength = i_len;
  assign bus0.iLCD_Ready = g_lcd[0].ready;
  assign bus1.iLCD_Ready = g_lcd[1].ready;

  assign rdy[0] = g_lcd[0].ready;      assign rdy[1] = g_lcd[1].ready;
  assign o_write[0] = bus0.oWrite;     assign o_write[1] = bus1.oWrite;
  assign o_busy[0] = bus0.oBusy;       assign o_busy[1] = bus1.oBusy;
  assign o_done[0] = bus0.oDone;       assign o_done[1] = bus1.oDone;
  assign o_err[0] = bus0.oError;       assign o_err[1] = bus1.oError;
  assign o_data[0] = bus0.oData;       assign o_data[1] = bus1.oData;
  assign o_idx[0] = bus0.oCharIndex;   assign o_idx[1] = bus1.oCharIndex;

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(int k, int kind, int data, int idx);
    item_t it;
    it.kind = kind;
    it.data = data;
    it.idx  = idx;
    if (k == 0) q0.push_back(it);
    else q1.push_back(it);
  endtask

  task automatic check_obs(int k, int kind, int data, int idx);
    item_t e;
    bit    got = 1'b0;
    tests++;
    if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
    if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
    if (!got) begin
      fails++;
      $display("FAIL dut%0d event: got kind=%0d data=%02h idx=%0d, expected nothing", k, kind, data, idx);
    end else if (e.kind != kind || (kind == KW && (e.data != data || e.idx != idx))) begin
      fails++;
      $display("FAIL dut%0d event: got kind=%0d data=%02h idx=%0d, expected kind=%0d data=%02h idx=%0d",
               k, kind, data, idx, e.kind, e.data, e.idx);
    end
  endtask

  // Monitor: every write, done pulse and error rise must match the next expected event.
  initial begin
    prev_err[0] = 1'b0;
    prev_err[1] = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int k = 0; k < 2; k++) begin
          if (o_write[k]) begin
            check_obs(k, KW, int'(o_data[k]), int'(o_idx[k]));
            check($sformatf("dut%0d write while not ready", k), int'(rdy[k]), 1);
          end
          if (o_done[k]) check_obs(k, KD, 0, 0);
          if (o_err[k] && !prev_err[k]) check_obs(k, KE, 0, 0);
        end
      end
      prev_err[0] = o_err[0];
      prev_err[1] = o_err[1];
    end
  end

  // Expected stream: first min(len,32) entries, cut at a null only when nulls terminate.
  task automatic plan_stream(int len);
    int l;
    l = (len > 32) ? 32 : len;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < l; i++) begin
        if (k == 0 && model_buf[i] == 0) break;
        push(k, KW, model_buf[i], i);
      end
      push(k, KD, 0, 0);
    end
  endtask

  task automatic host_write(int a, int d);
    wr_en = 1'b1;
    wr_addr = 5'(a);
    wr_data = 8'(d);
    model_buf[a] = d;
    foreach (q0[j]) if (q0[j].kind == KW && q0[j].idx == a) q0[j].data = d;
    foreach (q1[j]) if (q1[j].kind == KW && q1[j].idx == a) q1[j].data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic start(int len);
    plan_stream(len);
    i_start = 1'b1;
    i_len = 6'(len);
    @(negedge clk);
    i_start = 1'b0;
    check("oError cleared by start dut0", int'(o_err[0]), 0);
    check("oError cleared by start dut1", int'(o_err[1]), 0);
  endtask

  task automatic run_wait();
    int n = 0;
    while ((o_busy[0] || o_busy[1] || q0.size() > 0 || q1.size() > 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("stream completes within budget", int'(n < 20000), 1);
    check("dut0 expected events left", q0.size(), 0);
    check("dut1 expected events left", q1.size(), 0);
  endtask

  task automatic wait_index(int idx);
    int n = 0;
    while (!(o_idx[0] == 5'(idx) && !o_write[0] && !o_write[1]) && n < 10000) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("reach char %0d", idx), int'(n < 10000), 1);
  endtask

  task automatic check_reset_outputs();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("dut%0d reset oWrite", k), int'(o_write[k]), 0);
      check($sformatf("dut%0d reset oBusy", k), int'(o_busy[k]), 0);
      check($sformatf("dut%0d reset oDone", k), int'(o_done[k]), 0);
      check($sformatf("dut%0d reset oError", k), int'(o_err[k]), 0);
      check($sformatf("dut%0d reset oData", k), int'(o_data[k]), 0);
      check($sformatf("dut%0d reset oCharIndex", k), int'(o_idx[k]), 0);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hello [5];
    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    // HELLO with slow controller; a mid-stream iStart must be ignored.
    busy_len = 100;
    for (int i = 0; i < 5; i++) host_write(i, hello[i]);
    start(5);
    wait_index(1);
    i_start = 1'b1;
    i_len = 6'd3;
    @(negedge clk);
    i_start = 1'b0;
    run_wait();
    check("HELLO oError", int'(o_err[0]), 0);

    // Embedded null: dut0 stops at it, dut1 streams it.
    busy_len = 3;
    host_write(0, 8'h41); host_write(1, 8'h42); host_write(2, 8'h00); host_write(3, 8'h43);
    start(4);
    run_wait();

    // Zero length: busy for one cycle, done pulse the cycle after.
    start(0);
    check("len0 oBusy cycle1", int'(o_busy[0]), 1);
    check("len0 oDone cycle1", int'(o_done[0]), 0);
    @(negedge clk);
    check("len0 oBusy cycle2", int'(o_busy[0]), 0);
    check("len0 oDone cycle2", int'(o_done[0]), 1);
    run_wait();

    // Controller that never drops ready: error after 64 WAIT_BUSY cycles.
    host_write(0, 8'h5A);
    stuck = 1'b1;
    plan_stream(0);
    q0.delete(); q1.delete();
    push(0, KW, 8'h5A, 0); push(0, KE, 0, 0);
    push(1, KW, 8'h5A, 0); push(1, KE, 0, 0);
    i_start = 1'b1; i_len = 6'd3;
    @(negedge clk);
    i_start = 1'b0;
    n = 0;
    while (!o_write[0] && n < 50) begin @(negedge clk); n++; end
    check("stuck first write seen", int'(n < 50), 1);
    n = 0;
    while (!o_err[0] && n < 200) begin @(negedge clk); n++; end
    check("timeout cycles from write to oError", n, 65);
    check("timeout back to idle", int'(o_busy[0]), 0);
    run_wait();
    check("oError sticky", int'(o_err[0]), 1);
    stuck = 1'b0;
    start(0);
    run_wait();

    // Rewrites mid-stream: entry 0 already sent, entry 31 still pending.
    busy_len = 6;
    for (int i = 0; i < 32; i++) host_write(i, $urandom_range(1, 255));
    start(32);
    wait_index(2);
    host_write(0, $urandom_range(1, 255));
    host_write(31, $urandom_range(1, 255));
    run_wait();

    // Randomized buffers and lengths, including lengths beyond the buffer depth.
    for (int r = 0; r < 6; r++) begin
      busy_len = $urandom_range(1, 12);
      for (int i = 0; i < 32; i++)
        host_write(i, ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 255));
      start($urandom_range(0, 40));
      run_wait();
    end

    // Reset during character 10; the buffer must read back as all spaces.
    busy_len = 4;
    for (int i = 0; i < 32; i++) host_write(i, $urandom_range(1, 255));
    start(32);
    wait_index(10);
    rst_n = 1'b0;
    q0.delete(); q1.delete();
    for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;
    @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);
    start(63);
    run_wait();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
